// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/ready on both sides.
// Optional occupancy port enabled by defining PIPE_STAGE_BUF_COUNT_EN.
module pipe_stage_buf #(
    parameter  int N     = 16,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready
`ifdef PIPE_STAGE_BUF_COUNT_EN
    ,
    output logic [CW-1:0] count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_occ;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_wp_next;
    logic [PW-1:0] w_rp_next;

    // in_ready is a pure function of occupancy so no ready path crosses the stage
    assign in_ready  = (r_occ != CW'(DEPTH));
    assign out_valid = (r_occ != '0);
    assign out_data  = out_valid ? r_mem[r_rp] : '0;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    assign w_wp_next = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    assign w_rp_next = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= in_data;
                r_wp        <= w_wp_next;
            end
            if (w_pop) r_rp <= w_rp_next;
            if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
        end
    end

`ifdef PIPE_STAGE_BUF_COUNT_EN
    assign count = r_occ;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances share stimulus,
// each checked every cycle against a queue-based reference model.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_data;
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_data;
`ifdef PIPE_STAGE_BUF_COUNT_EN
    logic [1:0]  a_count;
    logic [1:0]  b_count;
`endif

    logic [15:0] q2[$];
    logic [15:0] q3[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.N(16), .DEPTH(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready)
`ifdef PIPE_STAGE_BUF_COUNT_EN
        ,
        .count     (a_count)
`endif
    );

    pipe_stage_buf #(.N(16), .DEPTH(3)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready)
`ifdef PIPE_STAGE_BUF_COUNT_EN
        ,
        .count     (b_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] ea;
        logic [15:0] eb;
        ea = (q2.size() != 0) ? q2[0] : 16'h0;
        eb = (q3.size() != 0) ? q3[0] : 16'h0;
        chk("a_out_valid", 32'(a_out_valid), 32'(q2.size() != 0));
        chk("a_out_data",  32'(a_out_data),  32'(ea));
        chk("a_in_ready",  32'(a_in_ready),  32'(q2.size() != 2));
        chk("b_out_valid", 32'(b_out_valid), 32'(q3.size() != 0));
        chk("b_out_data",  32'(b_out_data),  32'(eb));
        chk("b_in_ready",  32'(b_in_ready),  32'(q3.size() != 3));
`ifdef PIPE_STAGE_BUF_COUNT_EN
        chk("a_count", 32'(a_count), 32'(q2.size()));
        chk("b_count", 32'(b_count), 32'(q3.size()));
`endif
    endtask

    // Apply the FIFO rules to the model for the upcoming edge, using current inputs.
    task automatic model_edge();
        bit push_a, pop_a, push_b, pop_b;
        if (!reset || flush) begin
            q2.delete();
            q3.delete();
        end else begin
            push_a = in_valid && (q2.size() < 2);
            pop_a  = out_ready && (q2.size() > 0);
            push_b = in_valid && (q3.size() < 3);
            pop_b  = out_ready && (q3.size() > 0);
            if (pop_a)  void'(q2.pop_front());
            if (push_a) q2.push_back(in_data);
            if (pop_b)  void'(q3.pop_front());
            if (push_b) q3.push_back(in_data);
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        #2;
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // fill and backpressure
        drive(1'b1, 16'hAAAA, 1'b0); cycle();
        drive(1'b1, 16'hBBBB, 1'b0); cycle();
        chk("full_in_ready", 32'(a_in_ready), 32'd0);
        drive(1'b1, 16'hCCCC, 1'b0); cycle();
        drive(1'b0, 16'h0, 1'b1);
        chk("drain_0", 32'(a_out_data), 32'hAAAA);
        cycle();
        chk("drain_1", 32'(a_out_data), 32'hBBBB);
        cycle();
        chk("drain_empty", 32'(a_out_valid), 32'd0);
        cycle();

        // simultaneous push and pop at occupancy 1
        drive(1'b1, 16'h0001, 1'b0); cycle();
        drive(1'b1, 16'h0002, 1'b1); cycle();
        chk("simul_data",  32'(a_out_data),  32'h0002);
        chk("simul_valid", 32'(a_out_valid), 32'd1);
        drive(1'b0, 16'h0, 1'b1); cycle();

        // streaming 0..15 at one transfer per cycle
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 16'(i), 1'b1);
            if (i > 0) chk("stream_data", 32'(a_out_data), 32'(i - 1));
            chk("stream_ready", 32'(a_in_ready), 32'd1);
            cycle();
        end
        drive(1'b0, 16'h0, 1'b1);
        chk("stream_last", 32'(a_out_data), 32'd15);
        cycle();
        cycle();

        // flush beats a concurrent push and pop
        drive(1'b1, 16'h1111, 1'b0); cycle();
        drive(1'b1, 16'h2222, 1'b0); cycle();
        flush = 1'b1;
        drive(1'b1, 16'h5555, 1'b1); cycle();
        flush = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        chk("flush_out_valid", 32'(a_out_valid), 32'd0);
        chk("flush_in_ready",  32'(a_in_ready),  32'd1);
        chk("flush_b_valid",   32'(b_out_valid), 32'd0);
        cycle(); cycle();

        // asynchronous reset with two entries stored
        drive(1'b1, 16'h7777, 1'b0); cycle();
        drive(1'b1, 16'h8888, 1'b0); cycle();
        #2 reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(a_out_valid), 32'd0);
        chk("arst_out_data",  32'(a_out_data),  32'd0);
        chk("arst_in_ready",  32'(a_in_ready),  32'd1);
        chk("arst_b_valid",   32'(b_out_valid), 32'd0);
        q2.delete();
        q3.delete();
        #2 reset = 1'b1;
        drive(1'b1, 16'h1234, 1'b0); cycle();
        drive(1'b0, 16'h0, 1'b0);
        chk("post_rst_data", 32'(a_out_data), 32'h1234);
        cycle();
        drive(1'b0, 16'h0, 1'b1); cycle();

        // randomized traffic, exercises pointer wrap on both depths
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
